// File: rtl/lcd_rx_monitor.sv
// rtl/lcd_rx_monitor.sv - LCD RGB receive monitor: per-line width, per-frame line count, error flags, frame counter.
// Optional pixel checksum accumulator enabled by defining LCD_RX_CHECKSUM_EN.
module lcd_rx_monitor #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hd,
  input  logic        i_vd,
  input  logic        i_den,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic        o_frame_done,
  output logic        o_locked,
  output logic        o_h_err,
  output logic        o_v_err,
  output logic [10:0] o_width,
  output logic [9:0]  o_lines,
  output logic [7:0]  o_frames,
  output logic [15:0] o_chksum
);

  typedef enum logic {WAIT_VS, IN_FRAME} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_vd_q;
  logic        r_den_q;
  logic [10:0] r_pix;
  logic [9:0]  r_line;
  logic        r_h_err;

  logic        w_vd_fall;
  logic        w_den_fall;
  logic        w_active;
  logic        w_latch;
  logic        w_line_end;
  logic [9:0]  w_lines_now;
  logic        w_herr_now;
  logic        w_verr_now;
  logic [15:0] w_chk_now;

  assign w_vd_fall  = r_vd_q & ~i_vd;
  assign w_den_fall = r_den_q & ~i_den;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= WAIT_VS;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_VS:  if (w_vd_fall) w_next = IN_FRAME;
      IN_FRAME: w_next = IN_FRAME;
      default:  w_next = WAIT_VS;
    endcase
  end

  always_comb begin
    w_active = (r_state == IN_FRAME);
    w_latch  = w_active & w_vd_fall;
  end

  // A line ends on DEN falling, or is cut short when the frame edge arrives with DEN still high.
  always_comb begin
    w_line_end  = w_active & (w_den_fall | (w_latch & i_den));
    w_lines_now = r_line;
    if (w_line_end && r_line != 10'd1023) w_lines_now = r_line + 10'd1;
    w_herr_now  = r_h_err | (w_active & ((w_den_fall & (r_pix != 11'(H_ACTIVE)))
                                         | (w_latch & i_den)
                                         | (i_den & ~i_hd)));
    w_verr_now  = (w_lines_now != 10'(V_ACTIVE));
  end

`ifdef LCD_RX_CHECKSUM_EN
  logic [15:0] r_chk;
  logic [15:0] w_rgb_sum;

  assign w_rgb_sum = {8'd0, i_r} + {8'd0, i_g} + {8'd0, i_b};
  assign w_chk_now = r_chk + ((w_active && i_den) ? w_rgb_sum : 16'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_chk <= 16'd0;
    else if (w_latch)  r_chk <= 16'd0;
    else if (w_active) r_chk <= w_chk_now;
  end
`else
  logic w_unused_rgb;

  assign w_unused_rgb = ^{i_r, i_g, i_b};
  assign w_chk_now    = 16'd0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vd_q       <= 1'b0;
      r_den_q      <= 1'b0;
      r_pix        <= 11'd0;
      r_line       <= 10'd0;
      r_h_err      <= 1'b0;
      o_frame_done <= 1'b0;
      o_locked     <= 1'b0;
      o_h_err      <= 1'b0;
      o_v_err      <= 1'b0;
      o_width      <= 11'd0;
      o_lines      <= 10'd0;
      o_frames     <= 8'd0;
      o_chksum     <= 16'd0;
    end else begin
      r_vd_q       <= i_vd;
      r_den_q      <= i_den;
      o_frame_done <= w_latch;
      if (w_active && w_den_fall) o_width <= r_pix;
      if (w_latch) begin
        o_lines  <= w_lines_now;
        o_h_err  <= w_herr_now;
        o_v_err  <= w_verr_now;
        o_locked <= ~(w_herr_now | w_verr_now);
        o_frames <= o_frames + 8'd1;
        o_chksum <= w_chk_now;
        r_pix    <= 11'd0;
        r_line   <= 10'd0;
        r_h_err  <= 1'b0;
      end else if (w_active) begin
        if (i_den) begin
          if (r_pix != 11'd2047) r_pix <= r_pix + 11'd1;
        end else if (w_den_fall) begin
          r_pix <= 11'd0;
        end
        r_line  <= w_lines_now;
        r_h_err <= w_herr_now;
      end
    end
  end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb/tb_lcd_rx_monitor.sv - randomized frame stimulus checked against a per-frame line-width model.
module tb_lcd_rx_monitor;
  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst_n, hd, vd, den;
  logic [7:0]  r, g, b;
  logic        frame_done, locked, h_err, v_err;
  logic [10:0] width;
  logic [9:0]  lines;
  logic [7:0]  frames;
  logic [15:0] chksum;

  lcd_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hd(hd), .i_vd(vd), .i_den(den),
    .i_r(r), .i_g(g), .i_b(b),
    .o_frame_done(frame_done), .o_locked(locked), .o_h_err(h_err), .o_v_err(v_err),
    .o_width(width), .o_lines(lines), .o_frames(frames), .o_chksum(chksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: widths of completed lines in the current frame, plus frame-level accumulators.
  int q_w[$];
  bit m_hd_bad;
  int m_sum;
  int m_frames;
  bit in_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_herr"}, h_err, 0);
    check({tag, "_verr"}, v_err, 0);
    check({tag, "_width"}, width, 0);
    check({tag, "_lines"}, lines, 0);
    check({tag, "_frames"}, frames, 0);
    check({tag, "_chksum"}, chksum, 0);
  endtask

  task automatic set_pixel();
    r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
    den = 1'b1;
    if (in_frame) m_sum += int'(r) + int'(g) + int'(b);
  endtask

  task automatic drive_line(input int w, input bit hd_bad);
    den = 1'b0; hd = 1'b0;
    cyc(); cyc();
    hd = 1'b1;
    cyc();
    for (int i = 0; i < w; i++) begin
      hd = (hd_bad && i == 0) ? 1'b0 : 1'b1;
      set_pixel();
      cyc();
    end
    hd = 1'b1; den = 1'b0;
    cyc();
    if (in_frame) begin
      check("width", width, (w > 2047) ? 2047 : w);
      q_w.push_back(w);
      if (hd_bad) m_hd_bad = 1'b1;
    end
    cyc(); cyc();
  endtask

  task automatic frame_edge(input bit expect_done, input bit partial);
    int  n;
    bit  he, ve;
    vd = 1'b0;
    cyc();
    if (expect_done) begin
      n  = q_w.size() + (partial ? 1 : 0);
      if (n > 1023) n = 1023;
      he = m_hd_bad | partial;
      foreach (q_w[i]) if (q_w[i] != H) he = 1'b1;
      ve = (n != V);
      m_frames = (m_frames + 1) % 256;
      check("frame_done", frame_done, 1);
      check("lines", lines, n);
      check("h_err", h_err, he);
      check("v_err", v_err, ve);
      check("locked", locked, !(he || ve));
      check("frames", frames, m_frames);
`ifdef LCD_RX_CHECKSUM_EN
      check("chksum", chksum, m_sum % 65536);
`else
      check("chksum", chksum, 0);
`endif
    end else begin
      check("no_frame_done", frame_done, 0);
    end
    q_w.delete();
    m_hd_bad = 1'b0;
    m_sum    = 0;
    in_frame = 1'b1;
    cyc();
    check("done_pulse_end", frame_done, 0);
    vd = 1'b1;
  endtask

  task automatic run_frame(input int nl, input int odd_line, input int odd_w, input bit hd_bad_line);
    for (int l = 0; l < nl; l++)
      drive_line((l == odd_line) ? odd_w : H, hd_bad_line && (l == odd_line));
    frame_edge(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; vd = 1'b1; den = 1'b0; hd = 1'b1;
    r = 8'd0; g = 8'd0; b = 8'd0;
    in_frame = 1'b0; m_frames = 0; m_sum = 0; m_hd_bad = 1'b0;
    repeat (5) cyc();
    check_all_zero("rst");
    rst_n = 1'b1;
    cyc();
    check_all_zero("post_rst");

    // Lines before the first frame edge must be ignored.
    drive_line(H, 1'b0);
    check("wait_vs_width", width, 0);
    frame_edge(1'b0, 1'b0);

    run_frame(V, -1, H, 1'b0);
    run_frame(V, -1, H, 1'b0);
    run_frame(V, 3, H - 1, 1'b0);
    run_frame(V - 1, -1, H, 1'b0);
    run_frame(V, 5, H, 1'b1);
    run_frame(V, 2, 2050, 1'b0);
    run_frame(V + 1, -1, H, 1'b0);

    for (int f = 0; f < 6; f++) begin
      int nl, ol, ow;
      nl = V + int'($urandom_range(0, 2)) - 1;
      ol = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nl - 1)) : -1;
      ow = H + int'($urandom_range(0, 6)) - 3;
      run_frame(nl, ol, ow, $urandom_range(0, 3) == 0);
    end

    // DEN held high across the frame edge: partial line counted with a width error.
    for (int l = 0; l < 3; l++) drive_line(H, 1'b0);
    for (int i = 0; i < 5; i++) begin
      set_pixel();
      cyc();
    end
    set_pixel();
    frame_edge(1'b1, 1'b1);
    den = 1'b0;
    cyc(); cyc();

    // Reset mid-frame discards everything; the first edge afterwards only starts a frame.
    for (int l = 0; l < 4; l++) drive_line(H, 1'b0);
    rst_n = 1'b0;
    cyc(); cyc(); cyc();
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    in_frame = 1'b0; m_frames = 0; m_sum = 0; m_hd_bad = 1'b0; q_w.delete();
    cyc(); cyc();
    check_all_zero("mid_rst_rel");
    frame_edge(1'b0, 1'b0);
    run_frame(V, -1, H, 1'b0);
    run_frame(V, 1, H + 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
